// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy/fill engine: FSM states, mode
// encodings and the address width of the single-cycle memory interface.
package mem_pkg;

   localparam int MEM_AW = 16;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Address step; the 16-bit result wraps 0xFFFF -> 0x0000 by construction.
   function automatic logic [MEM_AW-1:0] addr_next(input logic [MEM_AW-1:0] a);
      return a + {{(MEM_AW-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Registered base-plus-offset address counter: load a base, then step by one
// word per increment, wrapping modulo 2^MEM_AW. Holds its value otherwise.
module mem_addr_gen
   import mem_pkg::*;
(
   input  logic              clock,
   input  logic              aclr,
   input  logic              load,
   input  logic              inc,
   input  logic [MEM_AW-1:0] base,
   output logic [MEM_AW-1:0] addr
);

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         addr <= '0;
      end else if (load) begin
         addr <= base;
      end else if (inc) begin
         addr <= addr_next(addr);
      end
   end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / constant fill initiator on the single-cycle memory interface.
// Streams one word per cycle, leaning on the fixed 1-cycle read latency of q.
module mem_copy_engine
   import mem_pkg::*;
#(
   parameter int width = 16
) (
   input  logic              clock,
   input  logic              aclr,
   input  logic              start,
   input  logic              mode,
   input  logic [MEM_AW-1:0] src_base,
   input  logic [MEM_AW-1:0] dst_base,
   input  logic [MEM_AW-1:0] length,
   input  logic [width-1:0]  fill_value,
   input  logic [width-1:0]  q,
   output logic [MEM_AW-1:0] rdaddress,
   output logic [MEM_AW-1:0] wraddress,
   output logic              wren,
   output logic [width-1:0]  data,
   output logic              busy,
   output logic              done
);

   state_t            state;
   logic              mode_r;
   logic [MEM_AW-1:0] dst_r;
   logic [width-1:0]  fill_r;
   logic [MEM_AW-1:0] cnt;

   logic              accept;
   logic              last;
   logic              rd_load;
   logic              rd_inc;
   logic              wr_load;
   logic              wr_inc;
   logic [MEM_AW-1:0] wr_base;

   assign accept = (state == ST_IDLE) && start && (length != '0);
   assign last   = (cnt == {{(MEM_AW-1){1'b0}}, 1'b1});

   // Copy: reads run in RUN; the write stream trails by one cycle, so the
   // write counter is loaded on the first RUN edge (wren still low).
   assign rd_load = accept && (mode == MODE_COPY);
   assign rd_inc  = (state == ST_RUN) && (mode_r == MODE_COPY) && !last;
   assign wr_load = (accept && (mode == MODE_FILL)) ||
                    ((state == ST_RUN) && (mode_r == MODE_COPY) && !wren);
   assign wr_inc  = (state == ST_RUN) && wren && ((mode_r == MODE_COPY) || !last);
   assign wr_base = (state == ST_IDLE) ? dst_base : dst_r;

   mem_addr_gen u_rd_gen (
      .clock (clock),
      .aclr  (aclr),
      .load  (rd_load),
      .inc   (rd_inc),
      .base  (src_base),
      .addr  (rdaddress)
   );

   mem_addr_gen u_wr_gen (
      .clock (clock),
      .aclr  (aclr),
      .load  (wr_load),
      .inc   (wr_inc),
      .base  (wr_base),
      .addr  (wraddress)
   );

   assign data = wren ? ((mode_r == MODE_FILL) ? fill_r : q) : '0;

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state  <= ST_IDLE;
         mode_r <= MODE_COPY;
         dst_r  <= '0;
         fill_r <= '0;
         cnt    <= '0;
         wren   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_r <= mode;
                  dst_r  <= dst_base;
                  fill_r <= fill_value;
                  cnt    <= length;
                  if (length == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                     wren  <= (mode == MODE_FILL);
                  end
               end
            end
            ST_RUN: begin
               if (mode_r == MODE_COPY) begin
                  wren <= 1'b1;
                  if (last) state <= ST_DRAIN;
                  else      cnt   <= cnt - 1'b1;
               end else if (last) begin
                  wren  <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DRAIN: begin
               wren  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a source memory model with 1-cycle read latency,
// a write scoreboard fed at stimulus time, and per-cycle control checks.
module tb_mem_copy_engine;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          aclr;
   logic          start;
   logic          mode;
   logic [15:0]   src_base;
   logic [15:0]   dst_base;
   logic [15:0]   length;
   logic [W-1:0]  fill_value;
   logic [W-1:0]  q;
   logic [15:0]   rdaddress;
   logic [15:0]   wraddress;
   logic          wren;
   logic [W-1:0]  data;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   mem_copy_engine #(.width(W)) dut (
      .clock      (clock),
      .aclr       (aclr),
      .start      (start),
      .mode       (mode),
      .src_base   (src_base),
      .dst_base   (dst_base),
      .length     (length),
      .fill_value (fill_value),
      .q          (q),
      .rdaddress  (rdaddress),
      .wraddress  (wraddress),
      .wren       (wren),
      .data       (data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   // Source memory contents: word at address a is a + 0x90 (0x10 -> 0xA0).
   function automatic logic [W-1:0] src_word(input logic [15:0] a);
      return a + 16'h0090;
   endfunction

   always @(posedge clock) q <= src_word(rdaddress);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Write scoreboard: every destination write must match the head of exp_q.
   always @(negedge clock) begin
      if (wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", {31'd0, wren}, 32'd0);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("wr_addr_data", {wraddress, data}, e);
         end
      end
   end

   task automatic scramble_inputs();
      mode       = 1'($urandom_range(0, 1));
      src_base   = 16'($urandom);
      dst_base   = 16'($urandom);
      length     = 16'($urandom);
      fill_value = 16'($urandom);
   endtask

   // Run one operation and check busy/done/rdaddress every cycle until done.
   task automatic do_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [15:0] f, input bit repulse);
      int total;
      logic [15:0] rd_hold;
      for (int i = 0; i < int'(l); i++) begin
         logic [15:0] a;
         a = d + 16'(i);
         if (m) exp_q.push_back({a, f});
         else   exp_q.push_back({a, src_word(s + 16'(i))});
      end
      total = (l == 16'd0) ? 1 : (m ? int'(l) + 1 : int'(l) + 2);
      @(negedge clock);
      rd_hold    = rdaddress;
      mode       = m;
      src_base   = s;
      dst_base   = d;
      length     = l;
      fill_value = f;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      scramble_inputs();
      for (int k = 1; k <= total; k++) begin
         @(negedge clock);
         check("busy", {31'd0, busy}, {31'd0, (k < total)});
         check("done", {31'd0, done}, {31'd0, (k == total)});
         if (m)
            check("rd_hold", {16'd0, rdaddress}, {16'd0, rd_hold});
         else if (k <= int'(l))
            check("rdaddress", {16'd0, rdaddress}, {16'd0, s + 16'(k - 1)});
         if (repulse && k == 2) begin
            scramble_inputs();
            length = 16'd2;
            start  = 1'b1;
         end
         if (repulse && k == 3) start = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("done_after", {31'd0, done}, 32'd0);
         check("busy_after", {31'd0, busy}, 32'd0);
      end
      check("writes_left", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      aclr  = 1'b1;
      start = 1'b0;
      scramble_inputs();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_rdaddress", {16'd0, rdaddress}, 32'd0);
      check("rst_wraddress", {16'd0, wraddress}, 32'd0);
      check("rst_wren", {31'd0, wren}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      aclr = 1'b0;

      do_op(1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0000, 1'b0);
      do_op(1'b1, 16'h0000, 16'h0200, 16'd3, 16'h5A5A, 1'b0);
      do_op(1'b0, 16'h1234, 16'h4321, 16'd0, 16'h0000, 1'b0);
      do_op(1'b0, 16'hFFFE, 16'hFFFF, 16'd3, 16'h0000, 1'b0);
      do_op(1'b0, 16'h0800, 16'h0900, 16'd6, 16'h0000, 1'b1);
      do_op(1'b1, 16'h0000, 16'hFFFE, 16'd1, 16'hBEEF, 1'b0);
      do_op(1'b0, 16'h0700, 16'h0600, 16'd1, 16'h0000, 1'b0);

      for (int r = 0; r < 6; r++)
         do_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               16'($urandom_range(1, 20)), 16'($urandom), 1'b0);

      // Reset in cycle 4 of an 8-word copy: only writes k=1..3 may appear.
      for (int i = 0; i < 3; i++)
         exp_q.push_back({16'h0400 + 16'(i), src_word(16'h0300 + 16'(i))});
      @(negedge clock);
      mode = 1'b0; src_base = 16'h0300; dst_base = 16'h0400; length = 16'd8;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(negedge clock);
      #1 aclr = 1'b1;
      #1;
      check("arst_wren", {31'd0, wren}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_rdaddress", {16'd0, rdaddress}, 32'd0);
      @(negedge clock);
      aclr = 1'b0;
      repeat (12) @(negedge clock);
      check("arst_writes", exp_q.size(), 32'd0);
      check("arst_busy_idle", {31'd0, busy}, 32'd0);
      exp_q.delete();

      do_op(1'b0, 16'h0020, 16'h0010, 16'd5, 16'h0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator (master) for the shared single-cycle memory interface: it drives rdaddress, wraddress, wren and data, and consumes q.
- Copies a block of words from a source memory's read port to a destination memory's write port, or fills the destination with a constant.
- Used for frame and sample-buffer initialisation and for buffer-to-buffer transfers.
- Sustains one word per cycle, relying on the interface's fixed 1-cycle read latency; no ready signalling.

Parameters:
- width, 16, data word width; matches the width parameter of the attached memories.

Ports:
- clock  in  1  system clock, rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- start  in  1  begin an operation; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_base  in  16  first source word address (copy mode only).
- dst_base  in  16  first destination word address.
- length  in  16  number of words; 0 = no-op.
- fill_value  in  width  constant written in fill mode.
- q  in  width  read data from the source memory, valid the cycle after rdaddress is presented.
- rdaddress  out  16  source memory read address.
- wraddress  out  16  destination memory write address.
- wren  out  1  destination write enable.
- data  out  width  destination write data.
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (aclr=1, asynchronous):
  - State returns to IDLE immediately.
  - rdaddress=0, wraddress=0, wren=0, busy=0, done=0.
  - Internal counters and latched parameters clear to 0.
  - Reset mid-operation aborts the transfer with no further writes; partial destination contents are left as-is.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch mode, src_base, dst_base, length and fill_value.
  - If length=0, go to DONE. Otherwise go to RUN.
  - Port changes after latching have no effect on the operation.
- Copy-mode timing (start sampled at edge E0):
  - Cycle k (k=1..N): rdaddress=src_base+(k-1).
  - Cycle k+1: wren=1, wraddress=dst_base+(k-1), data=q.
  - RUN covers cycles 1..N. DRAIN is cycle N+1, carrying the last write.
  - DONE is cycle N+2: done=1, wren=0.
- Fill-mode timing:
  - No reads; rdaddress holds its value.
  - Cycle k (k=1..N): wren=1, wraddress=dst_base+(k-1), data=fill_value.
  - DONE is cycle N+1. DRAIN is skipped.
- Output rules:
  - rdaddress, wraddress, wren, busy and done are registered.
  - data is a combinational mux of q (copy) or latched fill_value (fill), qualified by wren.
- busy=1 in RUN and DRAIN only.
- done=1 for exactly one cycle in DONE. The state then returns to IDLE.
- A start asserted in the DONE cycle is ignored. A start held high is re-sampled in the following IDLE cycle.
- start while busy is ignored and not queued.
- Address arithmetic is modulo 2^16: base+offset wraps 0xFFFF -> 0x0000 silently.
- The word counter is 16 bits. length=0xFFFF transfers 65535 words.
- Overlap restriction: copies where the destination range overlaps the source range with dst_base > src_base are unsupported and produce undefined results (read-during-write). Non-overlapping ranges and dst_base <= src_base are supported.
- Between operations, wraddress and rdaddress hold their last values and wren=0.

Decomposition:
- Shared package (mem_pkg):
  - State encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
  - Mode constants MODE_COPY=0, MODE_FILL=1.
  - Address width constant MEM_AW=16.
- One natural sub-module, mem_addr_gen:
  - Registered base-plus-offset counter with load, increment and 16-bit wrap.
  - Instantiated twice, once for the read address and once for the write address.

Test Plan:
- Copy src_base=0x0010, dst_base=0x0100, length=4, source memory preloaded 0xA0..0xA3 -> rdaddress 0x10..0x13 in cycles 1-4; wren high cycles 2-5 at 0x100..0x103 with data 0xA0..0xA3; done pulse cycle 6; busy high cycles 1-5.
- Fill dst_base=0x0200, length=3, fill_value=0x5A5A -> wren cycles 1-3 at 0x200..0x202 with data 0x5A5A; no rdaddress change; done cycle 4.
- length=0, start=1 -> wren never asserts, busy stays 0, done pulses in cycle 1.
- Wrap: copy src_base=0xFFFE, dst_base=0xFFFF, length=3 -> reads 0xFFFE, 0xFFFF, 0x0000; writes 0xFFFF, 0x0000, 0x0001.
- Reset mid-run: copy length=8, assert aclr in cycle 4 between edges -> wren, busy and done drop to 0 immediately without waiting for an edge; after release no further writes occur; a new start runs a correct transfer.
- start re-pulsed during busy with different parameters -> ignored; the original transfer completes unchanged with exactly one done pulse.
